cpu_debug_ctrl: RTL and testbench

Board-level debug front-end for the single-cycle CPU platform. It produces a CPU clock-enable pulse at a run-time selectable rate or by single step, and it manages a debounced memory-inspection address with up/down stepping and wrap. It also counts issued CPU cycles. It sits between the board buttons/switches and the CPU plus display path, and replaces the fixed divider and ad-hoc key-lock logic with one parametrised, glitch-free block.

---
 rtl/cpu_debug_ctrl.sv | 131 +++++++++++++
 tb/tb_cpu_debug_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_debug_ctrl.sv
// rtl/cpu_debug_ctrl.sv - CPU clock-enable generator, single step, debounced address stepper and cycle counter
module cpu_debug_ctrl #(
  parameter int                        DIV_W      = 32,
  parameter int                        N_MODES    = 4,
  parameter logic [N_MODES*DIV_W-1:0]  DIV_TABLE  = {32'd4, 32'd2500, 32'd25000, 32'd250000},
  parameter logic [DIV_W-1:0]          DIV_SLOW   = 32'd2500000,
  parameter int                        DEB_CYCLES = 250000,
  parameter int                        ADDR_W     = 10,
  parameter int                        ADDR_MAX   = 1023,
  parameter int                        CNT_W      = 32,
  localparam int                       MODE_W     = $clog2(N_MODES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_MODES-1:0] freq_req,
  input  logic               step_mode,
  input  logic               step_btn,
  input  logic               mem_view,
  input  logic               addr_up,
  input  logic               addr_dn,
  input  logic               cnt_clr,
  output logic               cpu_ce,
  output logic [MODE_W-1:0]  mode_idx,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [CNT_W-1:0]   cycle_count
);

  localparam int N_BTN = 3;
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(ADDR_MAX);

  // Button bit order: 0 = step, 1 = up, 2 = down
  logic [N_BTN-1:0] btn_raw, sync1, sync2, deb, deb_d, rise;
  logic [DEB_W-1:0] deb_cnt [N_BTN];

  assign btn_raw = {addr_dn, addr_up, step_btn};
  assign rise    = deb & ~deb_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int b = 0; b < N_BTN; b++) deb_cnt[b] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      deb_d <= deb;
      for (int b = 0; b < N_BTN; b++) begin
        if (sync2[b] == deb[b]) begin
          deb_cnt[b] <= '0;
        end else if (deb_cnt[b] == DEB_W'(DEB_CYCLES - 1)) begin
          deb[b]     <= sync2[b];
          deb_cnt[b] <= '0;
        end else begin
          deb_cnt[b] <= deb_cnt[b] + DEB_W'(1);
        end
      end
    end
  end

  logic [MODE_W-1:0] mode_nxt;
  logic [DIV_W-1:0]  div_raw, div_last, div_cnt, div_cnt_inc;

  // Lowest set request index wins; no request selects the slow default
  always_comb begin
    mode_nxt = MODE_W'(N_MODES);
    for (int i = N_MODES - 1; i >= 0; i--) begin
      if (freq_req[i]) mode_nxt = MODE_W'(i);
    end
  end

  // Table entry 0 sits in the most significant slice
  always_comb begin
    div_raw = DIV_SLOW;
    for (int i = 0; i < N_MODES; i++) begin
      if (mode_idx == MODE_W'(i)) div_raw = DIV_TABLE[(N_MODES-1-i)*DIV_W +: DIV_W];
    end
    div_last    = (div_raw == '0) ? '0 : div_raw - DIV_W'(1);
    div_cnt_inc = div_cnt + DIV_W'(1);
  end

  // cpu_ce is registered so it is high exactly while div_cnt == div-1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_idx <= MODE_W'(N_MODES);
      div_cnt  <= '0;
      cpu_ce   <= 1'b0;
    end else begin
      mode_idx <= mode_nxt;
      if (step_mode) begin
        div_cnt <= '0;
        cpu_ce  <= rise[0];
      end else if (mode_nxt != mode_idx) begin
        div_cnt <= '0;
        cpu_ce  <= 1'b0;
      end else if (div_cnt == div_last) begin
        div_cnt <= '0;
        cpu_ce  <= (div_last == '0);
      end else begin
        div_cnt <= div_cnt_inc;
        cpu_ce  <= (div_cnt_inc == div_last);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_count <= '0;
    end else if (cnt_clr) begin
      cycle_count <= '0;
    end else if (cpu_ce) begin
      cycle_count <= cycle_count + CNT_W'(1);
    end
  end

  // Simultaneous up and down edges cancel
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr <= '0;
    end else if (!mem_view) begin
      mem_addr <= '0;
    end else if (rise[1] && !rise[2]) begin
      mem_addr <= (mem_addr == ADDR_LAST) ? '0 : mem_addr + ADDR_W'(1);
    end else if (rise[2] && !rise[1]) begin
      mem_addr <= (mem_addr == '0) ? ADDR_LAST : mem_addr - ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// tb/tb_cpu_debug_ctrl.sv - directed table-driven bench for cpu_debug_ctrl
module tb_cpu_debug_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] freq_req;
  logic       step_mode, step_btn, mem_view, addr_up, addr_dn, cnt_clr;
  logic       cpu_ce;
  logic [2:0] mode_idx;
  logic [9:0] mem_addr;
  logic [31:0] cycle_count;

  int tests  = 0;
  int failed = 0;

  cpu_debug_ctrl #(
    .DIV_W(32), .N_MODES(4),
    .DIV_TABLE({32'd1, 32'd3, 32'd5, 32'd7}),
    .DIV_SLOW(32'd10), .DEB_CYCLES(4),
    .ADDR_W(10), .ADDR_MAX(5), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst), .freq_req(freq_req), .step_mode(step_mode),
    .step_btn(step_btn), .mem_view(mem_view), .addr_up(addr_up), .addr_dn(addr_dn),
    .cnt_clr(cnt_clr), .cpu_ce(cpu_ce), .mode_idx(mode_idx), .mem_addr(mem_addr),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] freq;
    int         n;
    int         exp_pulses;
    logic       exp_ce;
    int         exp_mode;
    int         exp_count;
  } rate_vec_t;

  typedef struct {
    logic up;
    logic dn;
    logic view;
    int   hold;
    int   exp_addr;
  } addr_vec_t;

  rate_vec_t rv[12];
  addr_vec_t av[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n, output int pulses);
    pulses = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (cpu_ce) pulses++;
    end
  endtask

  task automatic press(input logic up, input logic dn, input int hold);
    addr_up = up;
    addr_dn = dn;
    repeat (hold) tick();
    addr_up = 1'b0;
    addr_dn = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    int pulses;
    int first;

    // freq, ticks, pulses in window, cpu_ce at end, mode_idx, cycle_count
    rv[0]  = '{4'b0000, 9,  1, 1'b1, 4, 0};
    rv[1]  = '{4'b0000, 1,  0, 1'b0, 4, 1};
    rv[2]  = '{4'b0000, 9,  1, 1'b1, 4, 1};
    rv[3]  = '{4'b0000, 1,  0, 1'b0, 4, 2};
    rv[4]  = '{4'b0000, 10, 1, 1'b0, 4, 3};
    rv[5]  = '{4'b0000, 4,  0, 1'b0, 4, 3};
    rv[6]  = '{4'b0010, 1,  0, 1'b0, 1, 3};
    rv[7]  = '{4'b0010, 2,  1, 1'b1, 1, 3};
    rv[8]  = '{4'b0010, 3,  1, 1'b1, 1, 4};
    rv[9]  = '{4'b0010, 6,  2, 1'b1, 1, 6};
    rv[10] = '{4'b0011, 1,  0, 1'b0, 0, 7};
    rv[11] = '{4'b0011, 5,  5, 1'b1, 0, 11};

    // up, dn, mem_view, hold ticks, expected mem_addr
    av[0]  = '{1'b1, 1'b0, 1'b1, 8,  1};
    av[1]  = '{1'b1, 1'b0, 1'b1, 8,  2};
    av[2]  = '{1'b1, 1'b0, 1'b1, 20, 3};
    av[3]  = '{1'b1, 1'b0, 1'b1, 8,  4};
    av[4]  = '{1'b1, 1'b0, 1'b1, 8,  5};
    av[5]  = '{1'b1, 1'b0, 1'b1, 8,  0};
    av[6]  = '{1'b0, 1'b1, 1'b1, 8,  5};
    av[7]  = '{1'b1, 1'b1, 1'b1, 8,  5};
    av[8]  = '{1'b0, 1'b1, 1'b1, 8,  4};
    av[9]  = '{1'b0, 1'b1, 1'b1, 8,  3};
    av[10] = '{1'b1, 1'b0, 1'b0, 8,  0};
    av[11] = '{1'b1, 1'b0, 1'b0, 8,  0};
    av[12] = '{1'b1, 1'b0, 1'b1, 8,  1};

    rst = 1'b0;
    freq_req = 4'b0000;
    step_mode = 1'b0; step_btn = 1'b0; mem_view = 1'b0;
    addr_up = 1'b0; addr_dn = 1'b0; cnt_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("reset cpu_ce", 32'(cpu_ce), 0);
    check("reset mode_idx", 32'(mode_idx), 4);
    check("reset mem_addr", 32'(mem_addr), 0);
    check("reset cycle_count", cycle_count, 0);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      freq_req = rv[i].freq;
      run(rv[i].n, pulses);
      check($sformatf("rate[%0d] pulses", i), 32'(pulses), 32'(rv[i].exp_pulses));
      check($sformatf("rate[%0d] cpu_ce", i), 32'(cpu_ce), 32'(rv[i].exp_ce));
      check($sformatf("rate[%0d] mode_idx", i), 32'(mode_idx), 32'(rv[i].exp_mode));
      check($sformatf("rate[%0d] cycle_count", i), cycle_count, 32'(rv[i].exp_count));
    end

    // cnt_clr wins over a coincident cpu_ce
    cnt_clr = 1'b1;
    tick();
    check("clr with ce", cycle_count, 0);
    cnt_clr = 1'b0;
    tick();
    check("count after clr", cycle_count, 1);

    step_mode = 1'b1;
    tick();
    check("step entry ce", 32'(cpu_ce), 0);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("step clr", cycle_count, 0);

    // one short bounce, then a stable press, then release
    pulses = 0;
    first = -1;
    for (int k = 0; k < 25; k++) begin
      step_btn = (k == 0) || (k >= 2 && k < 12);
      tick();
      if (cpu_ce) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    step_btn = 1'b0;
    check("step pulses", 32'(pulses), 1);
    check("step latency", 32'(first), 8);
    check("step cycle_count", cycle_count, 1);

    mem_view = 1'b1;
    tick();
    for (int i = 0; i < 13; i++) begin
      mem_view = av[i].view;
      press(av[i].up, av[i].dn, av[i].hold);
      check($sformatf("addr[%0d]", i), 32'(mem_addr), 32'(av[i].exp_addr));
      if (i == 9) begin
        mem_view = 1'b0;
        tick();
        check("view off clears", 32'(mem_addr), 0);
      end
    end

    step_mode = 1'b0;
    freq_req = 4'b0010;
    run(5, pulses);
    check("pre-reset mode_idx", 32'(mode_idx), 1);
    check("pre-reset count", 32'(cycle_count > 1), 1);
    #2 rst = 1'b0;
    #1;
    check("async cpu_ce", 32'(cpu_ce), 0);
    check("async mode_idx", 32'(mode_idx), 4);
    check("async mem_addr", 32'(mem_addr), 0);
    check("async cycle_count", cycle_count, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("post-reset mode_idx", 32'(mode_idx), 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
